// File: rtl/exe_muldiv_stage.sv
// rtl/exe_muldiv_stage.sv - EXE stage ALU with an iterative 1-bit/cycle mul/div engine
// Single-cycle ops are combinational; MUL/MULHU/DIV/REM run IDLE -> RUN -> DONE and stall upstream.
module exe_muldiv_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      control,
  input  logic [31:0]     inst,
  input  logic            flush,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            stall,
  output logic            md_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MD_MUL   = 2'd0;
  localparam logic [1:0] MD_MULHU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_REM   = 2'd3;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  mq_q, mq_d;
  logic [XLEN-1:0]  dsr_q, dsr_d;

  logic [4:0]      shamt;
  logic            is_md;
  logic            op_signed;
  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            launch_neg;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ge;
  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] md_res;
  logic            unused_inst;

  assign shamt       = inst[10:6];
  assign unused_inst = ^{inst[31:11], inst[5:0]};
  assign is_md       = (control[3:2] == 2'b11);
  assign op_signed   = (control[1:0] != MD_MULHU);
  assign sa          = a[XLEN-1];
  assign sb          = b[XLEN-1];
  assign mag_a       = (op_signed && sa) ? -a : a;
  assign mag_b       = (op_signed && sb) ? -b : b;

  // Divide-by-zero keeps the all-ones magnitude quotient positive; remainder follows the dividend.
  always_comb begin
    launch_neg = 1'b0;
    case (control[1:0])
      MD_MUL:   launch_neg = sa ^ sb;
      MD_MULHU: launch_neg = 1'b0;
      MD_DIV:   launch_neg = (sa ^ sb) & (b != '0);
      MD_REM:   launch_neg = sa;
      default:  launch_neg = 1'b0;
    endcase
  end

  assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, dsr_q} : '0);
  assign div_shift = {acc_q, mq_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, dsr_q};
  assign div_ge    = (div_shift >= {1'b0, dsr_q});
  assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    dsr_d   = dsr_q;
    stall   = 1'b0;
    md_busy = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_md && !flush) begin
          stall   = 1'b1;
          state_d = S_RUN;
          cnt_d   = CNT_W'(XLEN - 1);
          op_d    = control[1:0];
          neg_d   = launch_neg;
          acc_d   = '0;
          mq_d    = mag_a;
          dsr_d   = mag_b;
        end
      end
      S_RUN: begin
        stall   = 1'b1;
        md_busy = 1'b1;
        if (op_q[1]) begin
          acc_d = div_rem;
          mq_d  = {mq_q[XLEN-2:0], div_ge};
        end else begin
          acc_d = mul_sum[XLEN:1];
          mq_d  = {mul_sum[0], mq_q[XLEN-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      op_d    = '0;
      neg_d   = 1'b0;
      acc_d   = '0;
      mq_d    = '0;
      dsr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      mq_q    <= '0;
      dsr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      dsr_q   <= dsr_d;
    end
  end

  // After the last step {acc, mq} holds the product, or remainder/quotient for divides.
  always_comb begin
    md_res = '0;
    case (op_q)
      MD_MUL:   md_res = neg_q ? -mq_q : mq_q;
      MD_MULHU: md_res = acc_q;
      MD_DIV:   md_res = neg_q ? -mq_q : mq_q;
      MD_REM:   md_res = neg_q ? -acc_q : acc_q;
      default:  md_res = '0;
    endcase
  end

  always_comb begin
    alu_result = '0;
    if (state_q == S_DONE) begin
      alu_result = md_res;
    end else if (state_q == S_IDLE) begin
      case (control)
        4'h0:    alu_result = a + b;
        4'h1:    alu_result = a - b;
        4'h2:    alu_result = a & b;
        4'h3:    alu_result = a | b;
        4'h4:    alu_result = a ^ b;
        4'h5:    alu_result = ~(a | b);
        4'h6:    alu_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        4'h7:    alu_result = {{(XLEN-1){1'b0}}, (a < b)};
        4'h8:    alu_result = a << shamt;
        4'h9:    alu_result = a >> shamt;
        4'hA:    alu_result = $signed(a) >>> shamt;
        4'hB:    alu_result = {b[15:0], {(XLEN-16){1'b0}}};
        default: alu_result = '0;
      endcase
    end
  end

  assign zero = (alu_result == '0);

endmodule
